// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, data width, default bit period.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ERR
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Latency: 2 cycles. Backpressure: none, free-running.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a fixed clock divider.
// Latency: o_irq 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none; re-arms immediately, o_frame_err held until i_rx_finish.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_rx_serial,
    input  logic                   i_rx_finish,
    output logic [UART_DATA_W-1:0] o_rx_data,
    output logic                   o_irq,
    output logic                   o_rx_busy,
    output logic                   o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(2);

    logic                   rx_s;
    uart_state_e            state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [UART_DATA_W-1:0] shreg;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx_serial),
        .q     (rx_s)
    );

    assign o_rx_busy = (state != ST_ARM) && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARM;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_rx_data   <= '0;
            o_irq       <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_irq <= 1'b0;
            case (state)
                // The synchronizer resets to idle-high, so its output only reflects
                // the real line once both flops have reloaded after reset.
                ST_ARM: begin
                    if (cnt != CNT_SETTLE) begin
                        cnt <= cnt + 1'b1;
                    end else if (rx_s) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_BIT) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_BIT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_rx_data <= shreg;
                            o_irq     <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_ERR;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Back through ARM so a held break must go high before a new frame.
                ST_ERR: begin
                    if (i_rx_finish) begin
                        o_frame_err <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_ARM;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a cycle-arithmetic reference of the receiver.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int IRQ_LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx_serial;
    logic       i_rx_finish;
    logic [7:0] o_rx_data;
    logic       o_irq;
    logic       o_rx_busy;
    logic       o_frame_err;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } irq_t;

    irq_t       irq_q[$];
    irq_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_serial (i_rx_serial),
        .i_rx_finish (i_rx_finish),
        .o_rx_data   (o_rx_data),
        .o_irq       (o_irq),
        .o_rx_busy   (o_rx_busy),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (o_irq === 1'b1) irq_q.push_back('{cyc, o_rx_data});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        i_rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Called on a negedge; the next posedge is the first one that sees the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        int t0;
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        if (stop_ok) begin
            exp_q.push_back('{t0 + IRQ_LAT, d});
            last_data = d;
        end
    endtask

    task automatic check_irqs(input string tag);
        check({tag, "_irq_count"}, irq_q.size(), exp_q.size());
        for (int i = 0; i < irq_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_irq_cycle"}, irq_q[i].cyc, exp_q[i].cyc);
            check({tag, "_irq_data"}, irq_q[i].d, exp_q[i].d);
        end
        irq_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0;
        logic [7:0] rb;

        rst_n       = 1'b0;
        i_rx_serial = 1'b1;
        i_rx_finish = 1'b0;
        #12;
        check("rst_data", o_rx_data, 8'h00);
        check("rst_irq", o_irq, 1'b0);
        check("rst_busy", o_rx_busy, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame with busy/irq timing around the start and stop samples.
        t0 = cyc + 1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                at_cyc(t0 + 1);
                check("single_busy_c1", o_rx_busy, 1'b0);
                at_cyc(t0 + 2);
                check("single_busy_c2", o_rx_busy, 1'b1);
                at_cyc(t0 + IRQ_LAT - 1);
                check("single_busy_pre", o_rx_busy, 1'b1);
                check("single_irq_pre", o_irq, 1'b0);
                at_cyc(t0 + IRQ_LAT);
                check("single_busy_irq", o_rx_busy, 1'b0);
                check("single_irq", o_irq, 1'b1);
                check("single_data", o_rx_data, 8'hA5);
            end
        join
        repeat (5) @(negedge clk);
        check_irqs("single");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        check_irqs("b2b");

        // Five-cycle low glitch, rejected at the start-bit sample.
        t0 = cyc + 1;
        i_rx_serial = 1'b0;
        at_cyc(t0 + 2);
        check("glitch_busy_c2", o_rx_busy, 1'b1);
        repeat (3) @(negedge clk);
        i_rx_serial = 1'b1;
        at_cyc(t0 + 2 + CPB / 2 - 1);
        check("glitch_busy_pre", o_rx_busy, 1'b1);
        at_cyc(t0 + 2 + CPB / 2);
        check("glitch_busy_end", o_rx_busy, 1'b0);
        check("glitch_ferr", o_frame_err, 1'b0);
        repeat (40) @(negedge clk);
        check_irqs("glitch");

        // Framing error; a finish pulse coincident with entering the error is ignored.
        t0 = cyc + 1;
        fork
            send_frame(8'h55, 1'b0);
            begin
                at_cyc(t0 + IRQ_LAT - 1);
                @(negedge clk);
                i_rx_finish = 1'b1;
                @(negedge clk);
                i_rx_finish = 1'b0;
                check("ferr_set", o_frame_err, 1'b1);
                check("ferr_busy", o_rx_busy, 1'b1);
                check("ferr_data_kept", o_rx_data, last_data);
                at_cyc(t0 + IRQ_LAT + 4);
                @(negedge clk);
                i_rx_finish = 1'b1;
                @(negedge clk);
                i_rx_finish = 1'b0;
                check("ferr_cleared", o_frame_err, 1'b0);
                check("ferr_busy_cleared", o_rx_busy, 1'b0);
            end
        join
        repeat (60) @(negedge clk);
        check("break_busy", o_rx_busy, 1'b0);
        check("break_ferr", o_frame_err, 1'b0);
        check_irqs("break");
        i_rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'($urandom), 1'b1);
        repeat (5) @(negedge clk);
        check_irqs("after_break");

        // Reset during data bit 4 while the line is low.
        rb = 8'($urandom) & 8'hEF;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        i_rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_busy_before", o_rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", o_rx_data, 8'h00);
        check("midrst_irq", o_irq, 1'b0);
        check("midrst_busy", o_rx_busy, 1'b0);
        check("midrst_ferr", o_frame_err, 1'b0);
        last_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("arm_busy_low_line", o_rx_busy, 1'b0);
        check_irqs("arm");
        i_rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        check("post_rst_data", o_rx_data, 8'h81);
        check_irqs("post_rst");

        // Two frames with no finish in between (overrun path).
        t0 = cyc + 1;
        fork
            begin
                send_frame(8'($urandom), 1'b1);
                send_frame(8'h81, 1'b1);
            end
            begin
                at_cyc(t0 + 10 * CPB + 5 * CPB);
                check("overrun_busy_2nd", o_rx_busy, 1'b1);
            end
        join
        repeat (5) @(negedge clk);
        check("overrun_data", o_rx_data, 8'h81);
        check_irqs("overrun");

        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_frame(8'($urandom), 1'b1);
        end
        repeat (10) @(negedge clk);
        check("rand_last_data", o_rx_data, last_data);
        check_irqs("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
